// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the WB stage and an in-order LLU result FIFO.
// Optional macro WBARB_BYPASS_EN: an LLU result may write directly when the slot is idle and the FIFO is empty.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        llu_valid,
  input  logic [4:0]  llu_rd,
  input  logic [31:0] llu_data,
  output logic        llu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic [31:0] pending_mask
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [7:0]    starve_cnt;
  logic [7:0]    starve_next;
  logic          slot_busy;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          bypass;

  assign slot_busy  = wb_valid && (wb_rd != 5'd0);
  assign fifo_empty = (count == '0);
  // Readiness ignores a same-cycle pop so the LLU never sees a combinational path from wb_valid.
  assign llu_ready  = !rst && (count < (AW+1)'(DEPTH));
  assign pop        = !rst && !slot_busy && !fifo_empty;

`ifdef WBARB_BYPASS_EN
  assign bypass = !rst && !slot_busy && fifo_empty && llu_valid && (llu_rd != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Results aimed at x0 complete the handshake but are never stored.
  assign push = llu_valid && llu_ready && (llu_rd != 5'd0) && !bypass;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (!rst) begin
      if (slot_busy) begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        rf_waddr = rd_mem[rd_ptr];
        rf_wdata = data_mem[rd_ptr];
      end else if (bypass) begin
        rf_we    = 1'b1;
        rf_waddr = llu_rd;
        rf_wdata = llu_data;
      end
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    starve_next = 8'd0;
    if (!pop && !fifo_empty) begin
      if (starve_cnt >= 8'(STARVE_MAX)) starve_next = 8'(STARVE_MAX);
      else                              starve_next = starve_cnt + 8'd1;
    end
  end

  always_comb begin
    pending_mask = 32'd0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((AW+1)'(i) < count) pending_mask[rd_mem[rd_ptr + AW'(i)]] = 1'b1;
      end
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= 8'd0;
      stall_req  <= 1'b0;
    end else begin
      count      <= count_next;
      starve_cnt <= starve_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      stall_req  <= (starve_next == 8'(STARVE_MAX)) || (count_next == (AW+1)'(DEPTH));
    end
  end

  // Storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= llu_rd;
      data_mem[wr_ptr] <= llu_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [31:0] pending_mask;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: buffered {rd,data} in arrival order, starvation age, stall level.
  logic [36:0] exp_q[$];
  int          m_starve = 0;
  bit          m_stall = 0;
  bit          m_stall_known = 0;
  bit          m_ready;
  bit          m_busy;
  bit          m_byp;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data),
    .llu_ready(llu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .pending_mask(pending_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld);
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    llu_valid = lv; llu_rd = lr; llu_data = ld;
  endtask

  task automatic settle_check();
    logic [31:0] mask;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    #1;
    m_busy  = wb_valid && (wb_rd != 5'd0);
    m_ready = !rst && (exp_q.size() < DEPTH);
    m_byp   = 1'b0;
    mask = 32'd0; we = 1'b0; wa = 5'd0; wd = 32'd0;
    if (!rst) begin
      foreach (exp_q[i]) mask[exp_q[i][36:32]] = 1'b1;
      mask[0] = 1'b0;
      if (m_busy) begin
        we = 1'b1; wa = wb_rd; wd = wb_data;
      end else if (exp_q.size() > 0) begin
        we = 1'b1; wa = exp_q[0][36:32]; wd = exp_q[0][31:0];
      end else begin
`ifdef WBARB_BYPASS_EN
        if (llu_valid && llu_rd != 5'd0) begin
          we = 1'b1; wa = llu_rd; wd = llu_data; m_byp = 1'b1;
        end
`endif
      end
    end
    check("llu_ready", {31'd0, llu_ready}, {31'd0, m_ready});
    check("rf_we", {31'd0, rf_we}, {31'd0, we});
    check("rf_waddr", {27'd0, rf_waddr}, {27'd0, wa});
    check("rf_wdata", rf_wdata, wd);
    check("pending_mask", pending_mask, mask);
    if (m_stall_known) check("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
  endtask

  task automatic tick();
    bit had;
    bit popped;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_starve = 0;
      m_stall  = 1'b0;
    end else begin
      had    = exp_q.size() > 0;
      popped = had && !m_busy;
      if (popped) void'(exp_q.pop_front());
      if (llu_valid && m_ready && llu_rd != 5'd0 && !m_byp) exp_q.push_back({llu_rd, llu_data});
      if (popped || !had)            m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      m_stall = (m_starve == STARVE_MAX) || (exp_q.size() == DEPTH);
    end
    m_stall_known = 1'b1;
    @(negedge clk);
  endtask

  task automatic cycle();
    settle_check();
    tick();
  endtask

  initial begin
    int ord[5];
    bit hs;
    ord[0] = 1; ord[1] = 2; ord[2] = 3; ord[3] = 4; ord[4] = 6;

    // Reset with both sources asserting.
    rst = 1'b1;
    drive(1'b1, 5'd4, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222);
    cycle();
    cycle();
    cycle();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle_check();
    check("rst_ready_after", {31'd0, llu_ready}, 32'd1);
    check("rst_no_entry", pending_mask, 32'd0);
    tick();

    // Idle drain through the FIFO.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle_check();
`ifndef WBARB_BYPASS_EN
    check("drain_we", {31'd0, rf_we}, 32'd1);
    check("drain_waddr", {27'd0, rf_waddr}, 32'd5);
    check("drain_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("drain_mask", pending_mask, 32'h0000_0020);
`endif
    tick();
    settle_check();
    check("drain_mask_clear", pending_mask, 32'd0);
    tick();

    // Starvation under a continuously busy pipeline.
    drive(1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd7, 32'h7777_0007);
    cycle();
    drive(1'b1, 5'd3, 32'hAAAA_0003, 1'b0, 5'd0, 32'd0);
    for (int c = 1; c <= 9; c++) begin
      settle_check();
      if (c == 8) check("starve_not_yet", {31'd0, stall_req}, 32'd0);
      if (c == 9) check("starve_stall", {31'd0, stall_req}, 32'd1);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle_check();
    check("starve_drain_waddr", {27'd0, rf_waddr}, 32'd7);
    check("starve_drain_we", {31'd0, rf_we}, 32'd1);
    tick();
    settle_check();
    check("starve_stall_fall", {31'd0, stall_req}, 32'd0);
    tick();

    // Fill the FIFO while the pipeline owns the port.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'd3, $urandom, 1'b1, 5'(k), $urandom);
      cycle();
    end
    drive(1'b1, 5'd3, $urandom, 1'b1, 5'd6, 32'h6666_0006);
    settle_check();
    check("full_ready", {31'd0, llu_ready}, 32'd0);
    check("full_stall", {31'd0, stall_req}, 32'd1);
    tick();
    wb_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle_check();
      check("full_order", {27'd0, rf_waddr}, ord[k]);
      hs = m_ready && llu_valid;
      tick();
      if (hs) llu_valid = 1'b0;
    end

    // x0 destinations on both sides.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0BAD_0000);
    settle_check();
    check("x0_ready", {31'd0, llu_ready}, 32'd1);
    check("x0_no_write", {31'd0, rf_we}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle_check();
    check("x0_discarded", pending_mask, 32'd0);
    tick();
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd9, 32'h9999_0009);
    cycle();
    drive(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'd0);
    settle_check();
    check("x0_slot_waddr", {27'd0, rf_waddr}, 32'd9);
    check("x0_slot_we", {31'd0, rf_we}, 32'd1);
    tick();

`ifdef WBARB_BYPASS_EN
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0000_1234);
    settle_check();
    check("byp_we", {31'd0, rf_we}, 32'd1);
    check("byp_waddr", {27'd0, rf_waddr}, 32'd12);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle_check();
    check("byp_not_queued", pending_mask, 32'd0);
    tick();
`endif

    // Random traffic, including occasional mid-stream resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 7) == 0) wb_rd = 5'd0;
      if ($urandom_range(0, 7) == 0) llu_rd = 5'd0;
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
